// File: rtl/pmod_pattern_gen.sv
// Purpose: PMOD/LED pattern generator (binary, chase, bounce, PWM breathe) with heartbeat LED.
// Latency: PAT is registered, 1 clock after each state update; first step tick at clock 2^STEP_BITS.
// Backpressure: none; free-running output block with no flow control.
//
// Ports:
//   CLK_48  - sole clock (48 MHz)
//   RST_N   - asynchronous active-low reset
//   BTN     - raw active-high mode button (only when BTN_MODE_EN is defined)
//   LED     - active-low heartbeat, toggles on every step tick
//   PAT     - CHANNELS-wide active-high pattern, registered
//   MODE    - current mode (0 binary, 1 chase, 2 bounce, 3 breathe), registered
//
// Optional feature macro: BTN_MODE_EN adds the BTN port, a 2-flop synchroniser,
// a debouncer and run-time mode cycling. Without it MODE is fixed at DEFAULT_MODE.
module pmod_pattern_gen #(
  parameter int CHANNELS     = 8,
  parameter int STEP_BITS    = 22,
  parameter int PWM_BITS     = 8,
  parameter int DEBOUNCE_CYC = 480000,
  parameter int DEFAULT_MODE = 0
) (
  input  logic                CLK_48,
  input  logic                RST_N,
`ifdef BTN_MODE_EN
  input  logic                BTN,
`endif
  output logic                LED,
  output logic [CHANNELS-1:0] PAT,
  output logic [1:0]          MODE
);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int POS_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam mode_t RESET_MODE = mode_t'(2'(DEFAULT_MODE));
  localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(CHANNELS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  // Elaboration-time parameter legality checks.
  if (CHANNELS < 2 || CHANNELS > 32) begin : g_bad_channels
    $error("pmod_pattern_gen: CHANNELS must be 2..32");
  end
  if (STEP_BITS < 1 || STEP_BITS > 31) begin : g_bad_step
    $error("pmod_pattern_gen: STEP_BITS must be 1..31");
  end
  if (PWM_BITS < 2 || PWM_BITS > 16) begin : g_bad_pwm
    $error("pmod_pattern_gen: PWM_BITS must be 2..16");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("pmod_pattern_gen: DEBOUNCE_CYC must be >= 2");
  end
  if (DEFAULT_MODE < 0 || DEFAULT_MODE > 3) begin : g_bad_mode
    $error("pmod_pattern_gen: DEFAULT_MODE must be 0..3");
  end

  mode_t                mode_q;
  logic                 mode_chg;   // one-cycle press pulse; resets pattern state
  logic [STEP_BITS-1:0] pre;
  logic                 tick;
  logic                 led;
  logic [CHANNELS-1:0]  cnt;
  logic [CHANNELS-1:0]  oh;
  logic [POS_W-1:0]     pos;
  logic                 pos_up;
  logic [PWM_BITS-1:0]  duty;
  logic                 duty_up;
  logic [PWM_BITS-1:0]  pwm;
  logic [CHANNELS-1:0]  pat_q;
  logic [CHANNELS-1:0]  pat_next;

  assign tick = &pre;

`ifdef BTN_MODE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            btn_s1;
  logic            btn_s2;
  logic            btn_deb;
  logic            btn_deb_q;
  logic [DB_W-1:0] db_cnt;

  // The debounced level follows the synchronised input only after
  // DEBOUNCE_CYC consecutive clocks of disagreement; any agreement restarts.
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_deb   <= 1'b0;
      btn_deb_q <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= BTN;
      btn_s2    <= btn_s1;
      btn_deb_q <= btn_deb;
      if (btn_s2 == btn_deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_deb <= btn_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Only the rising edge of the debounced level is a press.
  assign mode_chg = btn_deb & ~btn_deb_q;

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= RESET_MODE;
    end else if (mode_chg) begin
      mode_q <= mode_t'(mode_q + 2'd1);
    end
  end
`else
  assign mode_chg = 1'b0;
  assign mode_q   = RESET_MODE;
`endif

  // Prescaler, heartbeat and per-mode pattern state. A press takes
  // priority over a coincident tick, which is then dropped entirely.
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pre     <= '0;
      pwm     <= '0;
      led     <= 1'b1;
      cnt     <= '0;
      oh      <= ONE_HOT0;
      pos     <= '0;
      pos_up  <= 1'b1;
      duty    <= '0;
      duty_up <= 1'b1;
    end else begin
      pwm <= pwm + 1'b1;
      if (mode_chg) begin
        pre     <= '0;
        cnt     <= '0;
        oh      <= ONE_HOT0;
        pos     <= '0;
        pos_up  <= 1'b1;
        duty    <= '0;
        duty_up <= 1'b1;
      end else begin
        pre <= pre + 1'b1;
        if (tick) begin
          led <= ~led;
          case (mode_q)
            MODE_BINARY: cnt <= cnt + 1'b1;
            MODE_CHASE:  oh  <= {oh[CHANNELS-2:0], oh[CHANNELS-1]};
            MODE_BOUNCE: begin
              // Reverse at either end without dwelling on the end position.
              if (pos_up) begin
                if (pos == POS_LAST) begin
                  pos    <= POS_LAST - 1'b1;
                  pos_up <= 1'b0;
                end else begin
                  pos <= pos + 1'b1;
                end
              end else begin
                if (pos == '0) begin
                  pos    <= POS_W'(1);
                  pos_up <= 1'b1;
                end else begin
                  pos <= pos - 1'b1;
                end
              end
            end
            MODE_BREATHE: begin
              if (duty_up) begin
                if (duty == DUTY_MAX) begin
                  duty    <= DUTY_MAX - 1'b1;
                  duty_up <= 1'b0;
                end else begin
                  duty <= duty + 1'b1;
                end
              end else begin
                if (duty == '0) begin
                  duty    <= PWM_BITS'(1);
                  duty_up <= 1'b1;
                end else begin
                  duty <= duty - 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    pat_next = '0;
    case (mode_q)
      MODE_BINARY:  pat_next = cnt;
      MODE_CHASE:   pat_next = oh;
      MODE_BOUNCE:  pat_next = ONE_HOT0 << pos;
      MODE_BREATHE: pat_next = {CHANNELS{pwm < duty}};
    endcase
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pat_q <= '0;
    end else begin
      pat_q <= pat_next;
    end
  end

  assign PAT  = pat_q;
  assign LED  = led;
  assign MODE = mode_q;

endmodule

// File: tb/tb_pmod_pattern_gen.sv
`timescale 1ns/1ps
module tb_pmod_pattern_gen;

  localparam int C    = 4;
  localparam int SB   = 3;
  localparam int PB   = 3;
  localparam int DB   = 4;
  localparam int STEP = 1 << SB;
  localparam int PMAX = (1 << PB) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
`ifdef BTN_MODE_EN
  logic btn   = 1'b0;
`endif

  always #5 clk = ~clk;

  logic [C-1:0] pat_o  [4];
  logic         led_o  [4];
  logic [1:0]   mode_o [4];

  // One instance per reset mode so every pattern is exercised; instance 0
  // also receives the button when the feature is built in.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    pmod_pattern_gen #(
      .CHANNELS(C), .STEP_BITS(SB), .PWM_BITS(PB),
      .DEBOUNCE_CYC(DB), .DEFAULT_MODE(g)
    ) u_dut (
      .CLK_48(clk),
      .RST_N (rst_n),
`ifdef BTN_MODE_EN
      .BTN   ((g == 0) ? btn : 1'b0),
`endif
      .LED   (led_o[g]),
      .PAT   (pat_o[g]),
      .MODE  (mode_o[g])
    );
  end

  typedef struct packed {
    logic [C-1:0] pat;
    logic         led;
    logic [1:0]   mode;
  } exp_t;

  exp_t sb_q [4][$];
  int   press_q [$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: counts clocks since the last reset/mode change and
  // ticks since then; the pattern is a closed-form function of the tick count.
  int m_mode [4];
  int m_k    [4];
  int m_j    [4];
  int m_led  [4];
  int m_pwm;
  int edge_n;

  function automatic logic [C-1:0] ref_pat(int mode, int k, int pwm);
    int p;
    int d;
    case (mode)
      0: return C'(k % (1 << C));
      1: return C'(1 << (k % C));
      2: begin
        p = k % (2 * C - 2);
        if (p >= C) p = 2 * C - 2 - p;
        return C'(1 << p);
      end
      default: begin
        d = k % (2 * PMAX);
        if (d > PMAX) d = 2 * PMAX - d;
        return (pwm < d) ? {C{1'b1}} : {C{1'b0}};
      end
    endcase
  endfunction

  task automatic chk(string name, int inst, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] t=%0t edge=%0d: got %0h expected %0h",
                  name, inst, $time, edge_n, act, exp);
  endtask

  exp_t m_e;
  bit   m_press;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = i;
        m_k[i]    = 0;
        m_j[i]    = 0;
        m_led[i]  = 1;
        sb_q[i].delete();
      end
      m_pwm  = 0;
      edge_n = 0;
    end else begin
      edge_n++;
      m_press = 1'b0;
      if (press_q.size() > 0 && press_q[0] == edge_n) begin
        void'(press_q.pop_front());
        m_press = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        m_e.pat = ref_pat(m_mode[i], m_k[i], m_pwm);
        if (i == 0 && m_press) begin
          m_mode[i] = (m_mode[i] + 1) % 4;
          m_k[i]    = 0;
          m_j[i]    = 0;
        end else begin
          m_j[i]++;
          if (m_j[i] == STEP) begin
            m_j[i] = 0;
            m_k[i]++;
            m_led[i] ^= 1;
          end
        end
        m_e.led  = m_led[i][0];
        m_e.mode = 2'(m_mode[i]);
        sb_q[i].push_back(m_e);
      end
      m_pwm = (m_pwm + 1) % (PMAX + 1);
    end
  end

  // Monitor: compare every presented output against the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        chk("rst_pat", i, int'(pat_o[i]), 0);
        chk("rst_led", i, int'(led_o[i]), 1);
        chk("rst_mode", i, int'(mode_o[i]), i);
      end else if (sb_q[i].size() > 0) begin
        mon_e = sb_q[i].pop_front();
        chk("pat", i, int'(pat_o[i]), int'(mon_e.pat));
        chk("led", i, int'(led_o[i]), int'(mon_e.led));
        chk("mode", i, int'(mode_o[i]), int'(mon_e.mode));
      end
    end
  end

  // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
  task automatic do_async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("async_rst_pat", i, int'(pat_o[i]), 0);
      chk("async_rst_led", i, int'(led_o[i]), 1);
      chk("async_rst_mode", i, int'(mode_o[i]), i);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

`ifdef BTN_MODE_EN
  // Called 1 time unit after a clock edge. A level held for at least DB
  // sampling edges is a press, which changes MODE DB+2 edges after the
  // first sampling edge.
  task automatic btn_pulse(int hold, int gap);
    btn = 1'b1;
    if (hold >= DB) press_q.push_back(edge_n + 1 + DB + 2);
    repeat (hold) @(posedge clk);
    #1 btn = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Long enough for BINARY to wrap and BREATHE to do a full 0..7..0 sweep.
    repeat (300) @(posedge clk);
    for (int r = 0; r < 4; r++) begin
      do_async_reset();
      repeat ($urandom_range(20, 250)) @(posedge clk);
    end
`ifdef BTN_MODE_EN
    @(posedge clk);
    #1;
    btn_pulse(3, 12);            // glitch: no mode change
    for (int r = 0; r < 4; r++)  // four presses wrap the mode back to 0
      btn_pulse(4, 12);
    for (int r = 0; r < 10; r++)
      btn_pulse($urandom_range(1, 7), $urandom_range(8, 40));
    // Press whose mode change lands on a tick edge.
    begin
      int guard;
      guard = 0;
      while (m_j[0] != 1 && guard < 2 * STEP) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("align_timeout", 0, m_j[0], 1);
      btn_pulse(5, 40);
    end
`endif
    repeat (20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pmod_pattern_gen.md
# pmod_pattern_gen

Parametrised PMOD/LED pattern generator, successor to the board bring-up blinky. Drives `CHANNELS` PMOD/LED outputs from a prescaled step tick in one of four modes: binary count, chase, bounce and PWM breathe. Also drives an active-low heartbeat LED. Optionally a debounced button cycles the mode at run time. Sits at top level on CHOPIN/PRELUDE boards, clocked from `CLK_48`.

## Interface
- `CHANNELS`, default 8: pattern width, legal 2..32.
- `STEP_BITS`, default 22: one step tick every 2^`STEP_BITS` clocks (~87 ms at 48 MHz); legal 1..31.
- `PWM_BITS`, default 8: PWM counter and duty width, legal 2..16.
- `DEBOUNCE_CYC`, default 480000: clocks BTN must be stable to be accepted; legal ≥2.
- `DEFAULT_MODE`, default 0: mode after reset, 0..3.

Ports:
- `CLK_48`, in, 1: sole clock, 48 MHz.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `BTN`, in, 1: raw active-high button; present only with `BTN_MODE_EN`.
- `LED`, out, 1: heartbeat, active-low; toggles each step tick.
- `PAT`, out, `CHANNELS`: pattern outputs, active-high, registered.
- `MODE`, out, 2: current mode, registered.

## Operation
- Prescaler `pre` is `STEP_BITS` wide and free-running. `tick` is a 1-cycle pulse when `pre` is all-ones.
- Pattern state updates only on `tick`:
  - 0 BINARY: `cnt` (`CHANNELS` bits) +1, wrapping all-ones→0.
  - 1 CHASE: one-hot `oh` rotates left; bit `CHANNELS`-1 wraps to bit 0.
  - 2 BOUNCE: one-hot position `pos` moves toward `CHANNELS`-1, then back toward 0.
    - Direction reverses at each end; no dwell, so `CHANNELS`-1 is followed by `CHANNELS`-2.
  - 3 BREATHE: `duty` (`PWM_BITS`) steps up to 2^`PWM_BITS`-1, then down to 0, reversing at each end with no dwell.
- `PAT` source per mode:
  - Modes 0–2: `PAT` = `cnt`, `oh` or the one-hot of `pos`, respectively.
  - Mode 3: every bit = (`pwm` < `duty`), where `pwm` is a free-running `PWM_BITS` counter.
  - `duty`=0 gives constant 0; max duty gives low for 1 clock per PWM period.
- Mode change (button press only) does all of the following in one cycle:
  - `MODE` ← (`MODE`+1) mod 4, wrapping 3→0.
  - `pre`, `cnt` and `duty` ← 0; `oh` ← 1; `pos` ← 0; direction ← up.
  - `pwm` and `LED` are not affected.
- Simultaneous tick and mode change: the mode change wins and that tick is discarded.
- Debounce:
  - 2-flop synchroniser, then counter.
  - The debounced level takes the synchronised value after `DEBOUNCE_CYC` consecutive clocks of disagreement; any agreement clears the counter.
  - A press is a 0→1 edge of the debounced level. Release has no effect.
- Reset values (`RST_N`=0, asynchronous, also mid-operation):
  - `PAT`=0, `LED`=1 (off), `MODE`=`DEFAULT_MODE`.
  - `pre`=`cnt`=`duty`=`pwm`=`pos`=0, `oh`=1, direction up.
  - Synchroniser, debounced level and debounce counter all 0.

## Timing
- `PAT` is registered from the state, with 1 clock of latency after a state update.
- First tick occurs on clock 2^`STEP_BITS` after reset release. `PAT` shows the new pattern one clock later.
- `LED` toggles on the clock edge that samples `tick`.
- Button latency, with `BTN` held stable from clock edge E: `MODE` changes at edge E+`DEBOUNCE_CYC`+2, which comprises:
  - 2 synchroniser edges;
  - `DEBOUNCE_CYC` count edges;
  - 1 edge for the press-edge register.
- After a mode change, the next tick is 2^`STEP_BITS` clocks later.

## Configuration
- `BTN_MODE_EN` defined:
  - `BTN` port exists.
  - Synchroniser, debouncer and mode cycling are present.
- Undefined:
  - No `BTN` port and no debounce logic.
  - `MODE` is constant `DEFAULT_MODE`.
  - All pattern behaviour is otherwise identical.

## Test plan
Benches use `CHANNELS`=4, `STEP_BITS`=3, `PWM_BITS`=3, `DEBOUNCE_CYC`=4, `DEFAULT_MODE`=0.

- Reset, then run: `PAT`=0 until the first tick at clock 8, then `PAT`=1 at clock 9. Continue until 16 ticks wrap `PAT` F→0. `LED` alternates 0/1 per tick.
- Mode 1 via one press: `PAT` sequence 1,2,4,8,1. Assert `RST_N`=0 mid-sequence: `PAT`=0 and `MODE`=0 immediately, without waiting for a clock edge.
- Mode 2: `PAT` sequence 1,2,4,8,4,2,1,2, with no repeat at either end.
- Mode 3: `duty` sequence 0..7..0. At `duty`=3, `PAT`=F for 3 of every 8 clocks. At `duty`=0, `PAT`=0 constantly.
- Debounce (BTN_MODE_EN):
  - 3-clock glitch: `MODE` unchanged.
  - 4-clock stable press at edge E: `MODE` 0→1 at E+6.
  - Four presses: `MODE` wraps 3→0.
- Press landing on a tick cycle: tick is dropped, state is reset to the new mode's initial values, and the next tick is 8 clocks later.
